// File: rtl/fetch_queue.sv
// fetch_queue: in-order (pc, instr) buffer between fetch and decode.
// Circular buffer with read/write pointers and an occupancy counter.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 discard all entries and any same-cycle push
//   in_valid/in_ready     fetch-side handshake, in_pc/in_instr payload
//   out_valid/out_ready   decode-side handshake, out_pc/out_instr head
//   count                 current occupancy, 0..DEPTH
//
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, an
// incoming pair is presented combinationally on out_* (0-cycle latency).
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [63:0]      mem_q [DEPTH];

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;
    logic bypass;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & in_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty | bypass;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    // A bypassed pair consumed in the same cycle never touches storage.
    assign wr_en     = push & ~(bypass & out_ready);
    // Pops only advance storage when the head came from the buffer.
    assign rd_en     = pop & !empty;

    always_comb begin
        out_pc    = 32'h0;
        out_instr = 32'h0;
        if (!empty) begin
            {out_pc, out_instr} = mem_q[rptr_q];
        end else if (bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) wptr_d = wptr_q + PTR_W'(1);
            if (rd_en) rptr_d = rptr_q + PTR_W'(1);
            unique case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is intentionally left unreset; empty masks stale data.
    always_ff @(posedge clk) begin
        if (wr_en && !flush && !reset) begin
            mem_q[wptr_q] <= {in_pc, in_instr};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench for fetch_queue.
// Directed scenarios followed by randomized traffic.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [CNT_W-1:0] count;

    int  total;
    int  passed;
    bit  chk_en;

    logic [63:0] sb[$];
    logic [63:0] exp_pair;
    int          sz;
    bit          byp;
    bit          exp_valid;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference model + checker. Inputs are stable at the falling edge,
    // so the model predicts this cycle's outputs from the queue of
    // accepted pairs, then applies the transfers the rising edge will do.
    always @(negedge clk) begin
        if (chk_en) begin
            sz  = sb.size();
            byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (sz == 0) && in_valid && !flush;
`endif
            exp_valid = (sz != 0) || byp;
            chk("in_ready", 64'(in_ready), 64'(sz != DEPTH));
            chk("count", 64'(count), 64'(sz));
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            if (!exp_valid)
                chk("masked_out", {out_pc, out_instr}, 64'h0);
            if (exp_valid && out_ready) begin
                if (sz != 0) exp_pair = sb.pop_front();
                else exp_pair = {in_pc, in_instr};
                chk("pop_pair", {out_pc, out_instr}, exp_pair);
            end
            if (reset || flush) sb.delete();
            else if (in_valid && sz != DEPTH && !(byp && out_ready))
                sb.push_back({in_pc, in_instr});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            assert (count <= CNT_W'(DEPTH))
            else $error("FAIL count_overflow actual=%0d", count);
            assert (!(in_valid && in_ready && count == CNT_W'(DEPTH)))
            else $error("FAIL push_when_full count=%0d", count);
        end
    end

    task automatic step(input logic iv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic ordy,
                        input logic fl, input logic rs);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        chk_en    = 1'b0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'h0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // single push, visible next cycle
        step(1'b1, 32'hbfc0_0000, 32'h2408_0001, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("first_pc", 64'(out_pc), 64'(32'hbfc0_0000));
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);

        // fill to full, fifth push refused, drain in order
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'hbfc0_0000 + 32'(4 * i), $urandom, 1'b0,
                 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b1);

        // steady stream
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'hbfc0_0000 + 32'(4 * i), $urandom, 1'b1,
                 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // flush with a same-cycle push
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'hbfc0_0000 + 32'(4 * i), $urandom, 1'b0,
                 1'b0, 1'b0);
        step(1'b1, 32'hbfc0_0100, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // full queue, simultaneous push and pop
        for (int i = 0; i < 4; i++)
            step(1'b1, 32'hbfc0_0000 + 32'(4 * i), $urandom, 1'b0,
                 1'b0, 1'b0);
        step(1'b1, 32'hbfc0_0010, $urandom, 1'b1, 1'b0, 1'b0);
        chk("head_after_swap", 64'(out_pc), 64'(32'hbfc0_0004));
        for (int i = 0; i < 5; i++) idle(1'b1);

        // reset mid-operation
        for (int i = 0; i < 2; i++)
            step(1'b1, 32'hbfc0_0200 + 32'(4 * i), $urandom, 1'b0,
                 1'b0, 1'b0);
        step(1'b1, 32'hbfc0_0300, $urandom, 1'b1, 1'b0, 1'b1);
        idle(1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), {$urandom, 2'b00} >> 2,
                 $urandom, 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 79) == 0));
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
